// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types and constants.
package fetch_stage_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [XLEN-1:0]   RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INST_W-1:0] NOP_INST_DEFAULT = 32'h0000_0013;  // addi x0,x0,0

  // One decoded-side queue entry: instruction word plus the PC it was fetched from.
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   pc;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

  // Sequential next fetch address; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] addr);
    return addr + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_stage_sync_fifo.sv
// Small synchronous FIFO with flush; head is read combinationally from storage.
module fetch_stage_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  // A push into a full FIFO is only legal when a pop frees the head slot that same edge.
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy tracking; flush discards all entries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC ownership, credit-limited imem requests,
// output buffering towards decode and wrong-path squashing on redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0]   RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned       FIFO_DEPTH = 2,
  parameter logic [INST_W-1:0] NOP_INST   = NOP_INST_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  input  logic              halt,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [INST_W-1:0] id_inst,
  output logic [XLEN-1:0]   id_pc,
  output logic              busy
);

  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  last_pc_q;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] discard_q, discard_d;

  logic req_fire, resp_drop, resp_keep, credit_ok;
  logic out_push, out_pop;

  logic [ENTRY_W-1:0] out_rdata;
  fetch_entry_t       out_head, out_wdata;
  logic [CNT_W-1:0]   out_count;
  logic               out_empty, out_full_unused;

  logic [XLEN-1:0]    tag_pc;
  logic [CNT_W-1:0]   tag_count_unused;
  logic               tag_full_unused, tag_empty_unused;

  // Never request more words than the output buffer can absorb.
  assign credit_ok = ({1'b0, outst_q} + {1'b0, out_count}) < (CNT_W+1)'(FIFO_DEPTH);

  assign imem_req_valid = rst_n & ~halt & ~redirect_valid & credit_ok;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign resp_drop = imem_resp_valid & (discard_q != '0);
  assign resp_keep = imem_resp_valid & (discard_q == '0);

  // Responses landing in a redirect cycle are wrong-path and are not kept.
  assign out_wdata = '{inst: imem_resp_data, pc: tag_pc};
  assign out_push  = resp_keep & ~redirect_valid;
  assign out_pop   = id_valid & id_ready;
  assign out_head  = out_rdata;

  assign id_valid = ~out_empty;
  assign id_inst  = out_empty ? NOP_INST : out_head.inst;
  assign id_pc    = out_empty ? last_pc_q : out_head.pc;
  assign busy     = (outst_q != '0) | (out_count != '0);

  // Next PC, in-flight count and squash count.
  always_comb begin
    pc_d      = pc_q;
    outst_d   = outst_q + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);
    discard_d = discard_q;
    if (redirect_valid) begin
      // No request fires this cycle, so everything still in flight afterwards is stale.
      pc_d      = word_align(redirect_pc);
      discard_d = outst_q - CNT_W'(imem_resp_valid);
    end else begin
      if (req_fire)  pc_d      = next_pc(pc_q);
      if (resp_drop) discard_d = discard_q - CNT_W'(1);
    end
  end

  // State registers; id_pc keeps showing the last presented PC while empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      outst_q   <= '0;
      discard_q <= '0;
      last_pc_q <= '0;
    end else begin
      pc_q      <= pc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      last_pc_q <= id_pc;
    end
  end

  // Output queue of {inst, pc} towards decode.
  fetch_stage_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid),
    .push_i  (out_push),
    .wdata_i (out_wdata),
    .pop_i   (out_pop),
    .rdata_o (out_rdata),
    .count_o (out_count),
    .full_o  (out_full_unused),
    .empty_o (out_empty)
  );

  // Addresses of live (non-squashed) requests, consumed in response order.
  fetch_stage_sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid),
    .push_i  (req_fire),
    .wdata_i (pc_q),
    .pop_i   (resp_keep),
    .rdata_o (tag_pc),
    .count_o (tag_count_unused),
    .full_o  (tag_full_unused),
    .empty_o (tag_empty_unused)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a fixed-latency memory model.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  int mem_lat = 1;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2),
    .NOP_INST   (32'h0000_0013)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .halt            (halt),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_inst         (id_inst),
    .id_pc           (id_pc),
    .busy            (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // In-order memory: request accepted in cycle N answers in cycle N+mem_lat.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t pq[$];

  initial begin
    int    mcyc;
    pend_t p;
    mcyc = 0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        pq.delete();
      end else if (imem_req_valid && imem_req_ready) begin
        p.addr = imem_req_addr;
        p.due  = mcyc + mem_lat;
        pq.push_back(p);
      end
      mcyc++;
      #1;
      if (pq.size() > 0 && pq[0].due == mcyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = inst_of(pq[0].addr);
        void'(pq.pop_front());
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
      end
    end
  end

  // Holds reset for two edges; returns at a falling edge with rst_n still low.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    halt = 1'b0;
    id_ready = 1'b0;
    imem_req_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    imem_req_ready = 1'b1;
    id_ready = 1'b1;
    #1;
    vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL reset_id_valid: got %b expected 0", id_valid); end
    vectors++; if (id_inst !== NOP) begin miscompares++; $display("FAIL reset_id_inst: got %h expected %h", id_inst, NOP); end
    vectors++; if (id_pc !== 32'h0) begin miscompares++; $display("FAIL reset_id_pc: got %h expected 0", id_pc); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_req, exp_id;
    int c, got, first_c;
    do_reset();
    mem_lat = 1; imem_req_ready = 1'b1; id_ready = 1'b1; rst_n = 1'b1;
    exp_req = 32'h0; exp_id = 32'h0; got = 0; first_c = 0; c = 1;
    while (got < 6 && c < 40) begin
      #1;
      if (c == 1) begin
        vectors++; if (id_valid !== 1'b0 || id_inst !== NOP) begin miscompares++; $display("FAIL stream_c1_empty: got valid=%b inst=%h expected 0/%h", id_valid, id_inst, NOP); end
      end
      if (imem_req_valid && imem_req_ready) begin
        vectors++; if (imem_req_addr !== exp_req) begin miscompares++; $display("FAIL stream_req_addr: got %h expected %h", imem_req_addr, exp_req); end
        exp_req = exp_req + 32'd4;
      end
      if (id_valid) begin
        if (first_c == 0) first_c = c;
        vectors++; if (id_pc !== exp_id || id_inst !== inst_of(exp_id)) begin miscompares++; $display("FAIL stream_id: got pc=%h inst=%h expected pc=%h inst=%h", id_pc, id_inst, exp_id, inst_of(exp_id)); end
        exp_id = exp_id + 32'd4;
        got++;
      end
      @(negedge clk);
      c++;
    end
    vectors++; if (got != 6) begin miscompares++; $display("FAIL stream_timeout: got %0d instructions expected 6", got); end
    vectors++; if (first_c != 3) begin miscompares++; $display("FAIL stream_first_valid_cycle: got %0d expected 3", first_c); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_req, exp_id;
    int nreq, got, c;
    do_reset();
    mem_lat = 1; imem_req_ready = 1'b1; id_ready = 1'b0; rst_n = 1'b1;
    nreq = 0;
    for (int cy = 1; cy <= 5; cy++) begin
      #1;
      if (imem_req_valid && imem_req_ready) begin
        vectors++; if (imem_req_addr !== 32'(nreq * 4)) begin miscompares++; $display("FAIL bp_req_addr: got %h expected %h", imem_req_addr, 32'(nreq * 4)); end
        nreq++;
      end
      if (cy >= 3) begin
        vectors++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin miscompares++; $display("FAIL bp_stall_head: got valid=%b pc=%h expected 1/0", id_valid, id_pc); end
      end
      if (cy == 5) begin
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL bp_credit_block: got %b expected 0", imem_req_valid); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL bp_busy: got %b expected 1", busy); end
      end
      @(negedge clk);
    end
    vectors++; if (nreq != 2) begin miscompares++; $display("FAIL bp_req_count: got %0d expected 2", nreq); end
    id_ready = 1'b1;
    exp_req = 32'h8; exp_id = 32'h0; got = 0; c = 0;
    while (got < 3 && c < 30) begin
      #1;
      if (imem_req_valid && imem_req_ready) begin
        vectors++; if (imem_req_addr !== exp_req) begin miscompares++; $display("FAIL bp_resume_addr: got %h expected %h", imem_req_addr, exp_req); end
        exp_req = exp_req + 32'd4;
      end
      if (id_valid) begin
        vectors++; if (id_pc !== exp_id || id_inst !== inst_of(exp_id)) begin miscompares++; $display("FAIL bp_drain: got pc=%h inst=%h expected pc=%h", id_pc, id_inst, exp_id); end
        exp_id = exp_id + 32'd4;
        got++;
      end
      @(negedge clk);
      c++;
    end
    vectors++; if (got != 3) begin miscompares++; $display("FAIL bp_timeout: got %0d expected 3", got); end
  endtask

  task automatic test_redirect();
    logic [31:0] exp_req, exp_id;
    int got, c;
    do_reset();
    mem_lat = 3; imem_req_ready = 1'b1; id_ready = 1'b1; rst_n = 1'b1;
    #1;
    vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin miscompares++; $display("FAIL rd_req0: got v=%b a=%h expected 1/0", imem_req_valid, imem_req_addr); end
    @(negedge clk); #1;
    vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin miscompares++; $display("FAIL rd_req1: got v=%b a=%h expected 1/4", imem_req_valid, imem_req_addr); end
    @(negedge clk); #1;
    vectors++; if (imem_req_valid !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL rd_two_outstanding: got v=%b busy=%b expected 0/1", imem_req_valid, busy); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    @(negedge clk);
    redirect_valid = 1'b0;
    exp_req = 32'h100; exp_id = 32'h100; got = 0; c = 0;
    while (got < 2 && c < 30) begin
      #1;
      if (imem_req_valid && imem_req_ready) begin
        vectors++; if (imem_req_addr !== exp_req) begin miscompares++; $display("FAIL rd_target_addr: got %h expected %h", imem_req_addr, exp_req); end
        exp_req = exp_req + 32'd4;
      end
      if (id_valid) begin
        vectors++; if (id_pc !== exp_id || id_inst !== inst_of(exp_id)) begin miscompares++; $display("FAIL rd_target_id: got pc=%h inst=%h expected pc=%h", id_pc, id_inst, exp_id); end
        exp_id = exp_id + 32'd4;
        got++;
      end
      @(negedge clk);
      c++;
    end
    vectors++; if (got != 2) begin miscompares++; $display("FAIL rd_timeout: got %0d expected 2", got); end
  endtask

  task automatic test_redirect_with_resp();
    logic [31:0] exp_id, last_pc;
    int c, fired, got, seen_req;
    do_reset();
    mem_lat = 1; imem_req_ready = 1'b1; id_ready = 1'b1; rst_n = 1'b1;
    exp_id = 32'h0; last_pc = 32'h0; fired = 0; c = 0;
    while (fired == 0 && c < 20) begin
      #1;
      if (id_valid) begin
        vectors++; if (id_pc !== exp_id) begin miscompares++; $display("FAIL rr_pre_id: got %h expected %h", id_pc, exp_id); end
        last_pc = exp_id;
        exp_id = exp_id + 32'd4;
      end
      if (imem_resp_valid && imem_resp_data == inst_of(32'h8)) begin
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0203; fired = 1;
        #1;
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rr_no_req_in_redirect: got %b expected 0", imem_req_valid); end
      end
      @(negedge clk);
      c++;
    end
    redirect_valid = 1'b0;
    vectors++; if (fired != 1) begin miscompares++; $display("FAIL rr_resp8_timeout: got %0d expected 1", fired); end
    #1;
    vectors++; if (id_valid !== 1'b0 || id_pc !== last_pc) begin miscompares++; $display("FAIL rr_hold_pc: got v=%b pc=%h expected 0/%h", id_valid, id_pc, last_pc); end
    got = 0; seen_req = 0; c = 0;
    while (got < 1 && c < 20) begin
      if (imem_req_valid && imem_req_ready && seen_req == 0) begin
        seen_req = 1;
        vectors++; if (imem_req_addr !== 32'h200) begin miscompares++; $display("FAIL rr_next_addr: got %h expected 00000200", imem_req_addr); end
      end
      if (id_valid) begin
        vectors++; if (id_pc !== 32'h200 || id_inst !== inst_of(32'h200)) begin miscompares++; $display("FAIL rr_first_id: got pc=%h inst=%h expected pc=00000200", id_pc, id_inst); end
        got++;
      end
      @(negedge clk); #1;
      c++;
    end
    vectors++; if (got != 1) begin miscompares++; $display("FAIL rr_timeout: got %0d expected 1", got); end
  endtask

  task automatic test_halt();
    int got, c;
    do_reset();
    mem_lat = 3; imem_req_ready = 1'b1; id_ready = 1'b1; halt = 1'b0; rst_n = 1'b1;
    #1;
    vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin miscompares++; $display("FAIL halt_req0: got v=%b a=%h expected 1/0", imem_req_valid, imem_req_addr); end
    @(negedge clk);
    halt = 1'b1;
    #1;
    vectors++; if (imem_req_valid !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL halt_block: got v=%b busy=%b expected 0/1", imem_req_valid, busy); end
    got = 0; c = 0;
    while (got == 0 && c < 20) begin
      if (imem_req_valid !== 1'b0) begin
        vectors++; miscompares++; $display("FAIL halt_leak: got req_valid=%b expected 0", imem_req_valid);
      end
      if (id_valid) begin
        vectors++; if (id_pc !== 32'h0 || id_inst !== inst_of(32'h0)) begin miscompares++; $display("FAIL halt_pending: got pc=%h inst=%h expected pc=0 inst=%h", id_pc, id_inst, inst_of(32'h0)); end
        got = 1;
      end
      @(negedge clk); #1;
      c++;
    end
    vectors++; if (got != 1) begin miscompares++; $display("FAIL halt_timeout: got %0d expected 1", got); end
    vectors++; if (busy !== 1'b0 || id_valid !== 1'b0 || id_inst !== NOP) begin miscompares++; $display("FAIL halt_drained: got busy=%b v=%b inst=%h expected 0/0/%h", busy, id_valid, id_inst, NOP); end
    halt = 1'b0;
    #1;
    vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin miscompares++; $display("FAIL halt_resume: got v=%b a=%h expected 1/4", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_wrap_and_reset();
    logic [31:0] exp_req, exp_id;
    int got, c;
    do_reset();
    mem_lat = 1; imem_req_ready = 1'b1; id_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; rst_n = 1'b1;
    #1;
    vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_redirect_cycle: got %b expected 0", imem_req_valid); end
    @(negedge clk);
    redirect_valid = 1'b0;
    exp_req = 32'hFFFF_FFFC; exp_id = 32'hFFFF_FFFC; got = 0; c = 0;
    while (got < 2 && c < 20) begin
      #1;
      if (imem_req_valid && imem_req_ready) begin
        vectors++; if (imem_req_addr !== exp_req) begin miscompares++; $display("FAIL wrap_addr: got %h expected %h", imem_req_addr, exp_req); end
        exp_req = exp_req + 32'd4;
      end
      if (id_valid) begin
        vectors++; if (id_pc !== exp_id || id_inst !== inst_of(exp_id)) begin miscompares++; $display("FAIL wrap_id: got pc=%h inst=%h expected pc=%h", id_pc, id_inst, exp_id); end
        exp_id = exp_id + 32'd4;
        got++;
      end
      if (got < 2) begin
        @(negedge clk);
        c++;
      end
    end
    vectors++; if (got != 2 || busy !== 1'b1) begin miscompares++; $display("FAIL wrap_midburst: got n=%0d busy=%b expected 2/1", got, busy); end
    rst_n = 1'b0;
    @(negedge clk); #1;
    vectors++; if (id_valid !== 1'b0 || id_inst !== NOP) begin miscompares++; $display("FAIL midreset_id: got v=%b inst=%h expected 0/%h", id_valid, id_inst, NOP); end
    vectors++; if (imem_req_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL midreset_req: got v=%b busy=%b expected 0/0", imem_req_valid, busy); end
    rst_n = 1'b1;
    #1;
    vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin miscompares++; $display("FAIL midreset_pc: got v=%b a=%h expected 1/0", imem_req_valid, imem_req_addr); end
  endtask

  initial begin
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    halt = 1'b0;
    id_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_with_resp();
    test_halt();
    test_wrap_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
